// File: rtl/from8bit_pkg.sv
// rtl/from8bit_pkg.sv - mode encodings, word-length helper and align FSM states for from8bit_deser
package from8bit_pkg;

  localparam logic [1:0] MODE8   = 2'b00;
  localparam logic [1:0] MODE16  = 2'b01;
  localparam logic [1:0] MODE32  = 2'b10;
  localparam logic [1:0] MODERSV = 2'b11;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } align_state_e;

  // Index of the final byte of a word in the given mode; reserved mode behaves like 8b.
  function automatic logic [1:0] lastIdx(input logic [1:0] mode);
    logic [1:0] idx;
    case (mode)
      MODE8:   idx = 2'd0;
      MODE16:  idx = 2'd1;
      MODE32:  idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/byte_shift_acc.sv
// rtl/byte_shift_acc.sv - 32-bit byte shift/insert register with byte counter
// word_o is the word as it stands after this cycle's byte, so a completing byte is visible to the caller.
module byte_shift_acc #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  last_i,
  output logic [31:0] word_o,
  output logic [1:0]  byte_cnt_o
);

  logic [31:0] word_q, word_d, base_word;
  logic [1:0]  cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_word = clr_i ? 32'd0 : word_q;
    base_cnt  = clr_i ? 2'd0 : cnt_q;
    word_d    = base_word;
    cnt_d     = base_cnt;
    if (shift_i) begin
      if (MSB_FIRST) begin
        word_d = {base_word[23:0], byte_i};
      end else begin
        case (base_cnt)
          2'd0:    word_d[7:0]   = byte_i;
          2'd1:    word_d[15:8]  = byte_i;
          2'd2:    word_d[23:16] = byte_i;
          default: word_d[31:24] = byte_i;
        endcase
      end
      cnt_d = (base_cnt == last_i) ? 2'd0 : base_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      word_q <= 32'd0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o     = word_d;
  assign byte_cnt_o = cnt_q;

endmodule

// File: rtl/from8bit_deser.sv
// rtl/from8bit_deser.sv - byte stream to 8/16/32-bit word deserializer
// Optional word alignment via sowIn when FROM8BIT_ALIGN_EN is defined.
module from8bit_deser
  import from8bit_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic [7:0]  dataIn,
  input  logic        validIn,
  input  logic [1:0]  dataS,
`ifdef FROM8BIT_ALIGN_EN
  input  logic        sowIn,
`endif
  output logic [7:0]  dataOut8,
  output logic [15:0] dataOut16,
  output logic [31:0] dataOut32,
  output logic        validOut
);

  logic [1:0]  mode_q;
  logic [7:0]  out8_q;
  logic [15:0] out16_q;
  logic [31:0] out32_q;
  logic        valid_q;

  logic        mode_chg, rsv, accept, clr_base, clr, shift, done;
  logic [1:0]  byte_cnt, base_cnt, last;
  logic [31:0] word;

  assign rsv      = (dataS == MODERSV);
  assign mode_chg = enb && (dataS != mode_q);
  assign accept   = enb && validIn && !rsv;
  assign clr_base = enb && (mode_chg || rsv);
  assign last     = lastIdx(dataS);

`ifdef FROM8BIT_ALIGN_EN
  align_state_e state_q, state_eff;

  // A mode change re-enters HUNT on the same cycle, so its byte needs sowIn to be kept.
  assign state_eff = mode_chg ? HUNT : state_q;
  assign clr       = clr_base || (accept && sowIn);
  assign shift     = accept && ((state_eff == LOCK) || sowIn);
`else
  assign clr   = clr_base;
  assign shift = accept;
`endif

  assign base_cnt = clr ? 2'd0 : byte_cnt;
  assign done     = shift && (base_cnt == last);

  byte_shift_acc #(
    .MSB_FIRST (MSB_FIRST)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .shift_i    (shift),
    .byte_i     (dataIn),
    .last_i     (last),
    .word_o     (word),
    .byte_cnt_o (byte_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q  <= MODE8;
      out8_q  <= 8'd0;
      out16_q <= 16'd0;
      out32_q <= 32'd0;
      valid_q <= 1'b0;
`ifdef FROM8BIT_ALIGN_EN
      state_q <= HUNT;
`endif
    end else if (enb) begin
      mode_q  <= dataS;
      valid_q <= done;
      if (done) begin
        case (dataS)
          MODE8:   out8_q  <= word[7:0];
          MODE16:  out16_q <= word[15:0];
          MODE32:  out32_q <= word;
          default: ;
        endcase
      end
`ifdef FROM8BIT_ALIGN_EN
      state_q <= shift ? LOCK : state_eff;
`endif
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign dataOut8  = out8_q;
  assign dataOut16 = out16_q;
  assign dataOut32 = out32_q;
  assign validOut  = valid_q;

endmodule

// File: tb/tb_from8bit_deser.sv
// tb/tb_from8bit_deser.sv - directed self-checking bench for from8bit_deser (MSB-first and LSB-first instances)
module tb_from8bit_deser;

  logic        clk;
  logic        rst;
  logic        enb;
  logic [7:0]  dataIn;
  logic        validIn;
  logic [1:0]  dataS;
  logic        sowIn;

  logic [7:0]  m_out8, l_out8;
  logic [15:0] m_out16, l_out16;
  logic [31:0] m_out32, l_out32;
  logic        m_valid, l_valid;

  int n_checks = 0;
  int n_errors = 0;

  from8bit_deser #(.MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .dataIn    (dataIn),
    .validIn   (validIn),
    .dataS     (dataS),
`ifdef FROM8BIT_ALIGN_EN
    .sowIn     (sowIn),
`endif
    .dataOut8  (m_out8),
    .dataOut16 (m_out16),
    .dataOut32 (m_out32),
    .validOut  (m_valid)
  );

  from8bit_deser #(.MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .dataIn    (dataIn),
    .validIn   (validIn),
    .dataS     (dataS),
`ifdef FROM8BIT_ALIGN_EN
    .sowIn     (sowIn),
`endif
    .dataOut8  (l_out8),
    .dataOut16 (l_out16),
    .dataOut32 (l_out32),
    .validOut  (l_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic sow);
    dataIn  = b;
    sowIn   = sow;
    validIn = 1'b1;
    tick();
    validIn = 1'b0;
    sowIn   = 1'b0;
  endtask

  logic [7:0]  t1_bytes [5] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'h9A};
  logic [7:0]  t2_bytes [4] = '{8'hAD, 8'h43, 8'h54, 8'h3F};
  logic        t2_valid [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] t2_m16   [4] = '{16'h0000, 16'hAD43, 16'hAD43, 16'h543F};
  logic [15:0] t2_l16   [4] = '{16'h0000, 16'h43AD, 16'h43AD, 16'h3F54};
  logic [7:0]  t3_bytes [4] = '{8'h95, 8'hFD, 8'hAD, 8'h43};
  logic [7:0]  t4_bytes [4] = '{8'h94, 8'hD5, 8'h54, 8'h3F};

  initial begin
    rst = 1'b0; enb = 1'b1; dataIn = 8'h00; validIn = 1'b0; dataS = 2'b00; sowIn = 1'b0;
    tick();
    tick();
    check("rst_out8",  {24'd0, m_out8},  32'h0);
    check("rst_out16", {16'd0, m_out16}, 32'h0);
    check("rst_out32", m_out32,          32'h0);
    check("rst_valid", {31'd0, m_valid}, 32'h0);
    rst = 1'b1;
    tick();

    // 8-bit: every byte completes a word
    dataS = 2'b00;
    for (int i = 0; i < 5; i++) begin
      send(t1_bytes[i], 1'b1);
      check($sformatf("m8_out_%0d", i),   {24'd0, m_out8},  {24'd0, t1_bytes[i]});
      check($sformatf("m8_valid_%0d", i), {31'd0, m_valid}, 32'h1);
    end
    tick();
    check("m8_valid_idle", {31'd0, m_valid}, 32'h0);

    // 16-bit
    dataS = 2'b01;
    for (int i = 0; i < 4; i++) begin
      send(t2_bytes[i], (i % 2) == 0);
      check($sformatf("m16_valid_%0d", i), {31'd0, m_valid}, {31'd0, t2_valid[i]});
      check($sformatf("m16_out_%0d", i),   {16'd0, m_out16}, {16'd0, t2_m16[i]});
      check($sformatf("l16_out_%0d", i),   {16'd0, l_out16}, {16'd0, t2_l16[i]});
    end
    check("m16_hold8", {24'd0, m_out8}, 32'h9A);

    // 32-bit
    dataS = 2'b10;
    for (int i = 0; i < 4; i++) begin
      send(t3_bytes[i], i == 0);
      check($sformatf("m32_valid_%0d", i), {31'd0, m_valid}, (i == 3) ? 32'h1 : 32'h0);
    end
    check("m32_out",    m_out32,          32'h95FDAD43);
    check("l32_out",    l_out32,          32'h43ADFD95);
    check("m32_hold16", {16'd0, m_out16}, 32'h543F);

    // mode change mid-word discards the 16b partial
    dataS = 2'b01;
    send(8'hAD, 1'b1);
    check("mc_valid_16", {31'd0, m_valid}, 32'h0);
    dataS = 2'b10;
    for (int i = 0; i < 4; i++) begin
      send(t4_bytes[i], i == 0);
      check($sformatf("mc_valid_%0d", i), {31'd0, m_valid}, (i == 3) ? 32'h1 : 32'h0);
    end
    check("mc_m32",   m_out32,          32'h94D5543F);
    check("mc_l32",   l_out32,          32'h3F54D594);
    check("mc_m16",   {16'd0, m_out16}, 32'h543F);

    // enable hold with junk on the bus, then a validIn gap
    send(8'h03, 1'b1);
    send(8'h78, 1'b0);
    enb = 1'b0; validIn = 1'b1; dataIn = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("enb_valid_%0d", i), {31'd0, m_valid}, 32'h0);
    end
    validIn = 1'b0; enb = 1'b1;
    tick();
    check("gap_valid", {31'd0, m_valid}, 32'h0);
    send(8'hFD, 1'b0);
    check("hold_valid3", {31'd0, m_valid}, 32'h0);
    send(8'hAE, 1'b0);
    check("hold_valid4", {31'd0, m_valid}, 32'h1);
    check("hold_m32",    m_out32,          32'h0378FDAE);
    check("hold_l32",    l_out32,          32'hAEFD7803);

    // reset mid-word
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    rst = 1'b0;
    tick();
    check("rst2_out8",  {24'd0, m_out8},  32'h0);
    check("rst2_out16", {16'd0, m_out16}, 32'h0);
    check("rst2_out32", m_out32,          32'h0);
    check("rst2_valid", {31'd0, m_valid}, 32'h0);
    rst = 1'b1;
    send(8'h01, 1'b1);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    check("rst2_valid3", {31'd0, m_valid}, 32'h0);
    send(8'h04, 1'b0);
    check("rst2_valid4", {31'd0, m_valid}, 32'h1);
    check("rst2_m32",    m_out32,          32'h01020304);

    // reserved width ignores bytes
    dataS = 2'b11;
    send(8'h77, 1'b1);
    check("rsv_valid0", {31'd0, m_valid}, 32'h0);
    send(8'h88, 1'b1);
    check("rsv_valid1", {31'd0, m_valid}, 32'h0);
    check("rsv_out8",   {24'd0, m_out8},  32'h0);
    dataS = 2'b00;
    send(8'h5A, 1'b1);
    check("rsv_exit8",  {24'd0, m_out8},  32'h5A);
    check("rsv_exitv",  {31'd0, m_valid}, 32'h1);

`ifdef FROM8BIT_ALIGN_EN
    // alignment: hunt for sowIn, resync on a later sowIn
    dataS = 2'b01;
    send(8'h11, 1'b0);
    check("al_drop", {31'd0, m_valid}, 32'h0);
    send(8'h22, 1'b1);
    check("al_b0",   {31'd0, m_valid}, 32'h0);
    send(8'h33, 1'b0);
    check("al_w1v",  {31'd0, m_valid}, 32'h1);
    check("al_w1",   {16'd0, m_out16}, 32'h2233);
    send(8'h44, 1'b1);
    check("al_b2",   {31'd0, m_valid}, 32'h0);
    send(8'h55, 1'b0);
    check("al_w2v",  {31'd0, m_valid}, 32'h1);
    check("al_w2",   {16'd0, m_out16}, 32'h4455);
    send(8'h66, 1'b0);
    send(8'h77, 1'b1);
    check("al_resync", {31'd0, m_valid}, 32'h0);
    send(8'h88, 1'b0);
    check("al_w3",   {16'd0, m_out16}, 32'h7788);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
